// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU controller and datapath.
// The controller imports this same package, so both sides decode the control bundle identically.
package cpu_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {
    NSEL_RN   = 2'b00,
    NSEL_RD   = 2'b01,
    NSEL_RM   = 2'b10,
    NSEL_NONE = 2'b11
  } nsel_e;

  typedef enum logic [1:0] {
    VSEL_MDATA  = 2'b00,
    VSEL_SXIMM8 = 2'b01,
    VSEL_PC     = 2'b10,
    VSEL_C      = 2'b11
  } vsel_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_CMP = 2'b01,
    ALU_AND = 2'b10,
    ALU_MVN = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    SH_PASS = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_e;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
  } status_t;

endpackage

// File: rtl/regfile.sv
// Eight general registers: one combinational read port and one synchronous write port.
// A synchronous active-low clear wipes every entry.
module regfile #(
  parameter int W = cpu_pkg::WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         write,
  input  logic [2:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic [2:0]   raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] regs [8];

  // NOTE: every entry must read 0 after reset, so this array is built from
  // resettable flops rather than a RAM macro, which could not be cleared in one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (write) begin
      // NOTE: non-blocking assignment keeps the read port returning the old value
      // during a same-cycle write, which gives operand loads their read-before-write behaviour.
      regs[waddr] <= wdata;
    end
  end

  assign rdata = regs[raddr];

endmodule

// File: rtl/cpu_datapath.sv
// Execution datapath: register file, operand registers A and B, shifter, ALU, result register C and status.
// All sequencing comes from the external controller through the load and select strobes.
module cpu_datapath #(
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int PCW   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       nsel,
  input  logic [1:0]       vsel,
  input  logic [2:0]       rn,
  input  logic [2:0]       rd,
  input  logic [2:0]       rm,
  input  logic             write,
  input  logic             loada,
  input  logic             loadb,
  input  logic             loadc,
  input  logic             loads,
  input  logic             asel,
  input  logic             bsel,
  input  logic [1:0]       shift,
  input  logic [1:0]       aluop,
  input  logic [WIDTH-1:0] sximm8,
  input  logic [WIDTH-1:0] sximm5,
  input  logic [WIDTH-1:0] mdata,
  input  logic [PCW-1:0]   pc,
  output logic [WIDTH-1:0] datapath_out,
  output logic [2:0]       status
);

  import cpu_pkg::*;

  logic [2:0]       idx;
  logic             reg_we;
  logic [WIDTH-1:0] wdata, rdata;
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic [WIDTH-1:0] b_shifted, ain, bin, alu_out;
  logic             alu_v;
  status_t          status_q, status_d;

  // Index select; the "none" encoding still reads Rn but never writes.
  always_comb begin
    // NOTE: assigning a default before the case keeps every combinational
    // output driven on all paths, so no latch is inferred.
    idx = rn;
    case (nsel_e'(nsel))
      NSEL_RD: idx = rd;
      NSEL_RM: idx = rm;
      default: idx = rn;
    endcase
  end

  assign reg_we = write && (nsel_e'(nsel) != NSEL_NONE);

  always_comb begin
    wdata = c_q;
    case (vsel_e'(vsel))
      VSEL_MDATA:  wdata = mdata;
      VSEL_SXIMM8: wdata = sximm8;
      VSEL_PC:     wdata = {{(WIDTH-PCW){1'b0}}, pc};
      default:     wdata = c_q;
    endcase
  end

  regfile #(.W(WIDTH)) u_regfile (
    .clk   (clk),
    .reset (reset),
    .write (reg_we),
    .waddr (idx),
    .wdata (wdata),
    .raddr (idx),
    .rdata (rdata)
  );

  always_comb begin
    b_shifted = b_q;
    case (shift_e'(shift))
      SH_LSL:  b_shifted = {b_q[WIDTH-2:0], 1'b0};
      SH_LSR:  b_shifted = {1'b0, b_q[WIDTH-1:1]};
      SH_ASR:  b_shifted = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      default: b_shifted = b_q;
    endcase
  end

  assign ain = asel ? '0 : a_q;
  assign bin = bsel ? sximm5 : b_shifted;

  // Overflow: operands agree in sign (ADD) or differ (SUB) and the result sign flips away from A.
  always_comb begin
    alu_out = ain + bin;
    alu_v   = 1'b0;
    case (aluop_e'(aluop))
      ALU_ADD: begin
        alu_out = ain + bin;
        alu_v   = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_out[WIDTH-1] != ain[WIDTH-1]);
      end
      ALU_CMP: begin
        alu_out = ain - bin;
        alu_v   = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_out[WIDTH-1] != ain[WIDTH-1]);
      end
      ALU_AND: alu_out = ain & bin;
      default: alu_out = ~bin;
    endcase
  end

  assign status_d = '{z: (alu_out == '0), n: alu_out[WIDTH-1], v: alu_v};

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      if (loada) a_q      <= rdata;
      if (loadb) b_q      <= rdata;
      if (loadc) c_q      <= alu_out;
      if (loads) status_q <= status_d;
    end
  end

  assign datapath_out = c_q;
  assign status       = status_q;

endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

Execution datapath driven by the CPU finite-state-machine controller: eight 16-bit general registers, operand registers A and B, a shifter, an ALU, result register C and a 3-bit status register. Every register update happens on a rising `clk` edge when its load strobe from the controller is high. Control inputs mirror the controller's output bundle one for one. C drives both the data-memory address/write-data path and the register write-back mux.

## Interface
- `WIDTH`, 16: datapath word width. Only 16 is supported.
- `PCW`, 8: program-counter width, zero-extended on the `vsel` PC path.

- `clk` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low. Sampled on the `clk` rising edge; while low, all state is cleared.
- `nsel` in 2: register index select. 00=Rn, 01=Rd, 10=Rm, 11=none.
- `vsel` in 2: write-back source. 00=`mdata`, 01=`sximm8`, 10={zeros, `pc`}, 11=C.
- `rn`, `rd`, `rm` in 3 each: register fields from the instruction decoder.
- `write` in 1: register-file write strobe.
- `loada`, `loadb`, `loadc`, `loads` in 1 each: load strobes for A, B, C and status.
- `asel` in 1: 1 forces ALU input A to 0; 0 uses A.
- `bsel` in 1: 1 selects `sximm5` as ALU input B; 0 uses shifted B.
- `shift` in 2: 00=pass, 01=shift left 1 (LSB filled 0), 10=logical shift right 1, 11=arithmetic shift right 1.
- `aluop` in 2: 00=ADD, 01=SUB (A−B), 10=AND, 11=MVN (~B).
- `sximm8`, `sximm5` in 16 each: sign-extended immediates.
- `mdata` in 16: memory read data.
- `pc` in PCW: current program counter.
- `datapath_out` out 16: contents of C.
- `status` out 3: {Z, N, V}.

## Operation
- Register read is combinational: `rdata` = R[idx], where idx = rn, rd or rm per `nsel`. For `nsel`=11, idx = rn.
- Register write: when `write`=1 and `nsel`≠11, R[idx] ← `wdata` (selected by `vsel`) at the clock edge. When `nsel`=11, the write is suppressed.
- A ← `rdata` when `loada`=1. B ← `rdata` when `loadb`=1. Both may load in the same cycle.
- Shifter: operates on B according to `shift`.
- ALU inputs: Ain = `asel` ? 0 : A. Bin = `bsel` ? `sximm5` : shifted B.
- ALU arithmetic: 16-bit modulo; carry-out is discarded.
- C ← ALU result when `loadc`=1.
- Status ← {Z, N, V} of the current ALU result when `loads`=1:
  - Z = (result == 0).
  - N = result[15].
  - V = signed overflow for ADD/SUB; V = 0 for AND and MVN.
- `loadc` and `loads` may be asserted together; both capture the same result.
- Read-before-write: if `write` and `loada`/`loadb` target the same register in one cycle, A/B capture the old value.
- `vsel`=11 with `loadc`=1 in the same cycle: the old C is written back; the new C is visible next cycle.
- Strobes are independent; there is no internal FSM. Sequencing is owned entirely by the controller.

## Timing
- Reset: while `reset`=0 at a clock edge, R0–R7, A, B, C and status clear to 0. Therefore `datapath_out`=0 and `status`=3'b000 in the cycle after.
- Reset overrides all strobes asserted in the same cycle.
- Reset mid-sequence discards all partial results.
- Latency:
  - Write-back data is readable one cycle after `write`.
  - Loading an operand to producing C takes ≥1 cycle per stage: load A/B, then `loadc`, then `write` with `vsel`=C.
  - A full ALU instruction takes 4 controller cycles minimum.
- `datapath_out` and `status` change only on clock edges; they are never combinational from inputs.
- There is no handshake. Inputs are sampled only at rising `clk`; X on any unused input in a cycle with no strobe asserted has no effect.

## Structure
- Shared package `cpu_pkg`:
  - `nsel` encodings RN/RD/RM/NONE.
  - `vsel` encodings MDATA/SXIMM8/PC/C.
  - `aluop` encodings ADD/CMP/AND/MVN.
  - `shift` encodings.
  - WIDTH constant.
- The controller imports the same package so the encodings agree.
- Sub-module `regfile`: 8×16 storage, one combinational read port, one synchronous write port with write enable, synchronous active-low clear.
- Shifter and ALU stay as combinational logic inside `cpu_datapath`.

## Test plan
- Reset: drive `reset`=0 for 1 cycle with `write`=1, `vsel`=01, `sximm8`=0x0005 → all registers, C and status read 0.
- MOV immediate: `rn`=3, `nsel`=00, `vsel`=01, `sximm8`=0xFFF9, `write`=1 → R3=0xFFF9 next cycle.
- ADD with shift: R1=7, R2=3. Load A←R1 and B←R2 with `shift`=01, `aluop`=00, `loadc`=1, then `vsel`=11 write to R5 → R5=0x000D, `datapath_out`=0x000D.
- CMP overflow: A=0x8000, B=0x0001, `aluop`=01, `loads`=1 → status {Z,N,V}=3'b001. With A=B=0x1234 → 3'b100.
- MVN/ASR: B=0x8004, `shift`=11, `aluop`=11, `asel`=1, `loadc`=1 → C=0x3FFD. LDR address: A=0x0010, `bsel`=1, `sximm5`=0xFFFE, ADD → C=0x000E.
- Hazard: `write` to R4 (old value 0x0001, new value 0x00AA) while `loada`=1 with the same index → A=0x0001, and R4=0x00AA next cycle.
